register_file_sixteen: RTL and testbench

Sixteen-entry general-purpose register file that consumes the 16-bit one-hot write-enable vector produced by the 4-to-16 write-select demux in the datapath. It stores `WRITE_DATA` into the single selected register and provides two independently addressed, registered read ports. A write-to-read bypass and a sticky error flag catch malformed (multi-hot) enable vectors from the decode stage.

---
 rtl/register_file_sixteen_pkg.sv | 19 +
 rtl/register_file_sixteen_if.sv | 35 +++
 rtl/register_file_sixteen_onehot_write_check.sv | 34 +++
 rtl/register_file_sixteen.sv | 77 +++++++
 tb/tb_register_file_sixteen.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/register_file_sixteen_pkg.sv
// ============================================================================
// Module   : register_file_sixteen_pkg
// Purpose  : Shared datapath constants and typedefs for the 16-entry register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_sixteen_pkg;

  localparam int REG_COUNT          = 16;
  localparam int REG_SELECT_WIDTH   = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef logic [REG_SELECT_WIDTH-1:0] reg_index_t;
  typedef logic [REG_COUNT-1:0]        reg_onehot_t;

endpackage : register_file_sixteen_pkg

`default_nettype wire

// File: rtl/register_file_sixteen_if.sv
// ============================================================================
// Module   : register_file_sixteen_if
// Purpose  : Write/read bus between the decode stage and the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_sixteen_if
  import register_file_sixteen_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  reg_onehot_t           write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  reg_index_t            read_select_a;
  reg_index_t            read_select_b;
  logic                  error_clear;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic                  write_error;

  modport master (
    output write_enable, write_data, read_select_a, read_select_b, error_clear,
    input  read_data_a, read_data_b, write_error
  );

  modport slave (
    input  write_enable, write_data, read_select_a, read_select_b, error_clear,
    output read_data_a, read_data_b, write_error
  );

endinterface : register_file_sixteen_if

`default_nettype wire

// File: rtl/register_file_sixteen_onehot_write_check.sv
// ============================================================================
// Module   : onehot_write_check
// Purpose  : Classifies a write-enable vector as idle, valid (one-hot) or invalid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_write_check
  import register_file_sixteen_pkg::*;
(
  input  reg_onehot_t write_enable,
  output logic        valid,
  output logic        invalid,
  output reg_index_t  index
);

  int w_ones;

  always_comb begin
    w_ones  = $countones(write_enable);
    valid   = (w_ones == 1);
    invalid = (w_ones > 1);
    // OR-encoding is exact only for one-hot input; index is ignored otherwise.
    index   = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (write_enable[i]) begin
        index = index | reg_index_t'(i);
      end
    end
  end

endmodule : onehot_write_check

`default_nettype wire

// File: rtl/register_file_sixteen.sv
// ============================================================================
// Module   : register_file_sixteen
// Purpose  : 16-entry register file, two registered read ports with write
//            bypass, sticky error flag for multi-hot write enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sixteen
  import register_file_sixteen_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  register_file_sixteen_if.slave    bus
);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] r_read_data_a;
  logic [DATA_WIDTH-1:0] r_read_data_b;
  logic                  r_write_error;

  logic                  w_valid;
  logic                  w_invalid;
  reg_index_t            w_index;
  logic                  w_bypass_a;
  logic                  w_bypass_b;

  onehot_write_check u_onehot_write_check (
    .write_enable (bus.write_enable),
    .valid        (w_valid),
    .invalid      (w_invalid),
    .index        (w_index)
  );

  assign w_bypass_a = w_valid && (w_index == bus.read_select_a);
  assign w_bypass_b = w_valid && (w_index == bus.read_select_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_valid) begin
      r_regs[w_index] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data_a <= '0;
      r_read_data_b <= '0;
    end else begin
      r_read_data_a <= w_bypass_a ? bus.write_data : r_regs[bus.read_select_a];
      r_read_data_b <= w_bypass_b ? bus.write_data : r_regs[bus.read_select_b];
    end
  end

  // Set has priority over clear so a fresh fault is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_error <= 1'b0;
    end else if (w_invalid) begin
      r_write_error <= 1'b1;
    end else if (bus.error_clear) begin
      r_write_error <= 1'b0;
    end
  end

  assign bus.read_data_a = r_read_data_a;
  assign bus.read_data_b = r_read_data_b;
  assign bus.write_error = r_write_error;

endmodule : register_file_sixteen

`default_nettype wire

// File: tb/tb_register_file_sixteen.sv
// ============================================================================
// Module   : tb_register_file_sixteen
// Purpose  : Directed self-checking bench for register_file_sixteen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_sixteen;
  import register_file_sixteen_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  register_file_sixteen_if #(.DATA_WIDTH(16)) bus ();

  register_file_sixteen #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] we, input logic [15:0] data,
                       input logic [3:0] sa, input logic [3:0] sb, input logic clr);
    bus.write_enable  = we;
    bus.write_data    = data;
    bus.read_select_a = sa;
    bus.read_select_b = sb;
    bus.error_clear   = clr;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0);
    repeat (2) step();
    check("reset_rda", bus.read_data_a, 32'h0);
    check("reset_rdb", bus.read_data_b, 32'h0);
    check("reset_err", bus.write_error, 32'h0);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after writing 0xBEEF to R5
    drive(16'h0020, 16'hBEEF, 4'd0, 4'd0, 1'b0);
    step();
    drive(16'h0000, 16'h0000, 4'd5, 4'd5, 1'b0);
    step();
    check("pre_reset_r5", bus.read_data_a, 32'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rda", bus.read_data_a, 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("post_reset_r5", bus.read_data_a, 32'h0);
    check("post_reset_err", bus.write_error, 32'h0);

    // Write 0x1234 to R3, read the next cycle
    drive(16'h0008, 16'h1234, 4'd0, 4'd0, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(16'h0000, 16'h0000, 4'(i), 4'd3, 1'b0);
      step();
      check($sformatf("wr_r%0d", i), bus.read_data_a, (i == 3) ? 32'h1234 : 32'h0);
      check("wr_r3_b", bus.read_data_b, 32'h1234);
    end

    // Bypass on both ports
    drive(16'h0080, 16'h00AA, 4'd0, 4'd0, 1'b0);
    step();
    drive(16'h0080, 16'h5555, 4'd7, 4'd7, 1'b0);
    step();
    check("bypass_a", bus.read_data_a, 32'h5555);
    check("bypass_b", bus.read_data_b, 32'h5555);
    drive(16'h0000, 16'h0000, 4'd7, 4'd3, 1'b0);
    step();
    check("r7_stored", bus.read_data_a, 32'h5555);
    check("r3_kept", bus.read_data_b, 32'h1234);

    // Multi-hot enable: no write, no bypass, flag sets
    drive(16'h0002, 16'h1111, 4'd0, 4'd0, 1'b0);
    step();
    drive(16'h0004, 16'h2222, 4'd0, 4'd0, 1'b0);
    step();
    check("no_err_yet", bus.write_error, 32'h0);
    drive(16'h0006, 16'hFFFF, 4'd1, 4'd2, 1'b0);
    step();
    check("multihot_err", bus.write_error, 32'h1);
    check("multihot_rda", bus.read_data_a, 32'h1111);
    check("multihot_rdb", bus.read_data_b, 32'h2222);
    drive(16'h0000, 16'h0000, 4'd1, 4'd2, 1'b0);
    step();
    check("r1_unchanged", bus.read_data_a, 32'h1111);
    check("r2_unchanged", bus.read_data_b, 32'h2222);
    check("err_sticky", bus.write_error, 32'h1);

    // Set beats clear; then clear alone
    drive(16'h8001, 16'hABCD, 4'd0, 4'd15, 1'b1);
    step();
    check("set_wins_err", bus.write_error, 32'h1);
    check("set_wins_r0", bus.read_data_a, 32'h0);
    check("set_wins_r15", bus.read_data_b, 32'h0);
    drive(16'h0000, 16'h0000, 4'd0, 4'd15, 1'b1);
    step();
    check("clear_err", bus.write_error, 32'h0);
    check("r0_not_written", bus.read_data_a, 32'h0);
    check("r15_not_written", bus.read_data_b, 32'h0);
    drive(16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0);

    // Sweep: Ri = i * 0x0101, read pairs (i, 15-i)
    for (int i = 0; i < 16; i++) begin
      drive(16'(32'h1 << i), 16'(i * 16'h0101), 4'd0, 4'd0, 1'b0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drive(16'h0000, 16'h0000, 4'(i), 4'(15 - i), 1'b0);
      step();
      check($sformatf("sweep_a%0d", i), bus.read_data_a, 32'(i * 16'h0101));
      check($sformatf("sweep_b%0d", i), bus.read_data_b, 32'((15 - i) * 16'h0101));
      check("sweep_err", bus.write_error, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_register_file_sixteen

`default_nettype wire
